// File: rtl/envase_pkg.sv
// envase_pkg
//   Shared definitions for the parametrised bottling-line sequencer:
//   3-bit state encoding, fault codes, default phase durations at 50 MHz
//   and a small max() helper used to size the phase timer.
//   No ports (package).
package envase_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ESTEIRA     = 3'd1,
    ENCHENDO    = 3'd2,
    VEDANDO     = 3'd3,
    POSICAO_CQ  = 3'd4,
    DESCARTANDO = 3'd5,
    APROVADO    = 3'd6,
    FALHA       = 3'd7
  } estado_t;

  localparam logic [1:0] COD_NENHUMA = 2'b00;
  localparam logic [1:0] COD_ROLHA   = 2'b01;
  localparam logic [1:0] COD_ENCH    = 2'b10;

  localparam int T_ESTEIRA_DEF  = 50_000_000;
  localparam int T_VEDACAO_DEF  = 50_000_000;
  localparam int T_DESCARTE_DEF = 50_000_000;
  localparam int T_APROVADO_DEF = 50_000_000;
  localparam int T_ENCH_MAX_DEF = 250_000_000;
  localparam int T_CQ_MAX_DEF   = 500_000_000;
  localparam int LOTE_DEF       = 12;
  localparam int CNT_W_DEF      = 16;

  function automatic int max_t(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/temporizador_fase.sv
// temporizador_fase
//   Phase timer: up-counter cleared on state entry, saturating at all-ones,
//   with a terminal-count flag when the count reaches the loaded limit - 1
//   (i.e. on the last cycle of a phase that lasts 'lim' cycles).
// Ports
//   clk    in   1  clock
//   reset  in   1  synchronous active-high reset
//   clr    in   1  restart the count at 0 on the next cycle
//   lim    in   W  phase length in cycles (>= 1)
//   tc     out  1  current cycle is the last one of the phase
module temporizador_fase #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] lim,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == lim - W'(1));

endmodule

// File: rtl/fsm_envase_param.sv
// fsm_envase_param
//   Bottling-line main sequencer: conveyor -> fill -> seal -> QC ->
//   accept/discard, with configurable phase lengths, fill timeout, latched
//   fault with code, graceful stop and accepted/discarded/batch counters.
//   Optional build macro FSM_CQ_TIMEOUT_EN: undecided QC for T_CQ_MAX
//   cycles auto-rejects the bottle.
// Ports
//   clk, reset (sync, active-high)
//   cmd_iniciar, cmd_parar, cmd_reconhecer   operator commands
//   sensor_nivel, alarme_rolha, aprovado, reprovado   sensors / QC
//   esteira, valvula_ativa, vedacao_ativa, posicao_cq, descarte_ativo, falha
//                                            Moore state outputs
//   decrementar_rolha, garrafa_aprovada, duzia_completa   entry pulses
//   codigo_falha [1:0]                       fault code
//   cnt_aprovadas, cnt_descartadas [CNT_W]   bottle counters
//
// state       | meaning
// IDLE        | stopped, waiting for cmd_iniciar
// ESTEIRA     | conveyor indexing next bottle
// ENCHENDO    | fill valve open until full / alarm / timeout
// VEDANDO     | sealing actuator held
// POSICAO_CQ  | bottle at QC, waiting for decision
// DESCARTANDO | discard actuator held
// APROVADO    | accept phase held
// FALHA       | latched fault, waits for acknowledge with alarm clear
module fsm_envase_param
  import envase_pkg::*;
#(
  parameter int T_ESTEIRA  = T_ESTEIRA_DEF,
  parameter int T_VEDACAO  = T_VEDACAO_DEF,
  parameter int T_DESCARTE = T_DESCARTE_DEF,
  parameter int T_APROVADO = T_APROVADO_DEF,
  parameter int T_ENCH_MAX = T_ENCH_MAX_DEF,
  parameter int T_CQ_MAX   = T_CQ_MAX_DEF,
  parameter int LOTE       = LOTE_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_iniciar,
  input  logic             cmd_parar,
  input  logic             cmd_reconhecer,
  input  logic             sensor_nivel,
  input  logic             alarme_rolha,
  input  logic             aprovado,
  input  logic             reprovado,
  output logic             esteira,
  output logic             valvula_ativa,
  output logic             vedacao_ativa,
  output logic             decrementar_rolha,
  output logic             posicao_cq,
  output logic             descarte_ativo,
  output logic             garrafa_aprovada,
  output logic             duzia_completa,
  output logic             falha,
  output logic [1:0]       codigo_falha,
  output logic [CNT_W-1:0] cnt_aprovadas,
  output logic [CNT_W-1:0] cnt_descartadas
);

  localparam int T_MAX = max_t(max_t(max_t(T_ESTEIRA, T_VEDACAO), max_t(T_DESCARTE, T_APROVADO)),
                               max_t(T_ENCH_MAX, T_CQ_MAX));
  localparam int TW = $clog2(T_MAX + 1);
  localparam int LW = $clog2(LOTE + 1);

  estado_t       estado, estado_prox;
  logic [TW-1:0] lim;
  logic          tc;
  logic          parar_q;
  logic [LW-1:0] lote_q;
  logic          entra_ved, entra_apr, entra_desc;

  always_comb begin
    case (estado)
      ESTEIRA:     lim = TW'(T_ESTEIRA);
      ENCHENDO:    lim = TW'(T_ENCH_MAX);
      VEDANDO:     lim = TW'(T_VEDACAO);
      POSICAO_CQ:  lim = TW'(T_CQ_MAX);
      DESCARTANDO: lim = TW'(T_DESCARTE);
      APROVADO:    lim = TW'(T_APROVADO);
      default:     lim = TW'(1);
    endcase
  end

  // Timer restarts whenever the state changes, so tc always refers to the
  // number of cycles spent in the current state.
  temporizador_fase #(.W(TW)) u_tmr (
    .clk   (clk),
    .reset (reset),
    .clr   (estado_prox != estado),
    .lim   (lim),
    .tc    (tc)
  );

  always_comb begin
    estado_prox = estado;
    case (estado)
      IDLE:        if (cmd_iniciar) estado_prox = ESTEIRA;
      ESTEIRA:     if (tc) estado_prox = ENCHENDO;
      ENCHENDO: begin
        if (alarme_rolha)      estado_prox = FALHA;
        else if (sensor_nivel) estado_prox = VEDANDO;
        else if (tc)           estado_prox = FALHA;
      end
      VEDANDO:     if (tc) estado_prox = POSICAO_CQ;
      POSICAO_CQ: begin
        if (aprovado && !reprovado)      estado_prox = APROVADO;
        else if (reprovado && !aprovado) estado_prox = DESCARTANDO;
`ifdef FSM_CQ_TIMEOUT_EN
        else if (tc)                     estado_prox = DESCARTANDO;
`endif
      end
      DESCARTANDO, APROVADO:
        if (tc) estado_prox = parar_q ? IDLE : ESTEIRA;
      FALHA:       if (cmd_reconhecer && !alarme_rolha) estado_prox = IDLE;
      default:     estado_prox = IDLE;
    endcase
  end

  assign entra_ved  = (estado_prox == VEDANDO)     && (estado != VEDANDO);
  assign entra_apr  = (estado_prox == APROVADO)    && (estado != APROVADO);
  assign entra_desc = (estado_prox == DESCARTANDO) && (estado != DESCARTANDO);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado            <= IDLE;
      parar_q           <= 1'b0;
      codigo_falha      <= COD_NENHUMA;
      lote_q            <= '0;
      cnt_aprovadas     <= '0;
      cnt_descartadas   <= '0;
      decrementar_rolha <= 1'b0;
      garrafa_aprovada  <= 1'b0;
      duzia_completa    <= 1'b0;
    end else begin
      estado            <= estado_prox;
      decrementar_rolha <= entra_ved;
      garrafa_aprovada  <= entra_apr;
      duzia_completa    <= entra_apr && (lote_q == LW'(LOTE - 1));

      if (estado == IDLE && estado_prox == ESTEIRA) begin
        parar_q <= 1'b0;
      end else if (cmd_parar && estado != IDLE && estado != FALHA) begin
        parar_q <= 1'b1;
      end

      if (estado == ENCHENDO && estado_prox == FALHA) begin
        codigo_falha <= alarme_rolha ? COD_ROLHA : COD_ENCH;
      end else if (estado == FALHA && estado_prox == IDLE) begin
        codigo_falha <= COD_NENHUMA;
      end

      if (entra_apr) begin
        cnt_aprovadas <= cnt_aprovadas + CNT_W'(1);
        lote_q        <= (lote_q == LW'(LOTE - 1)) ? '0 : lote_q + LW'(1);
      end

      if (entra_desc && cnt_descartadas != '1) begin
        cnt_descartadas <= cnt_descartadas + CNT_W'(1);
      end
    end
  end

  assign esteira        = (estado == ESTEIRA);
  assign valvula_ativa  = (estado == ENCHENDO);
  assign vedacao_ativa  = (estado == VEDANDO);
  assign posicao_cq     = (estado == POSICAO_CQ);
  assign descarte_ativo = (estado == DESCARTANDO);
  assign falha          = (estado == FALHA);

endmodule

// File: tb/tb_fsm_envase_param.sv
module tb_fsm_envase_param;

  localparam int T_EST = 4, T_VED = 4, T_DESC = 4, T_APR = 5, T_ENCH = 6, T_CQ = 8;

  logic clk = 1'b0;
  logic reset;
  logic cmd_iniciar, cmd_parar, cmd_reconhecer, sensor_nivel, alarme_rolha, aprovado, reprovado;
  logic esteira, valvula_ativa, vedacao_ativa, decrementar_rolha, posicao_cq, descarte_ativo;
  logic garrafa_aprovada, duzia_completa, falha;
  logic [1:0] codigo_falha;
  logic [3:0] cnt_aprovadas, cnt_descartadas;

  fsm_envase_param #(
    .T_ESTEIRA(T_EST), .T_VEDACAO(T_VED), .T_DESCARTE(T_DESC), .T_APROVADO(T_APR),
    .T_ENCH_MAX(T_ENCH), .T_CQ_MAX(T_CQ), .LOTE(3), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_iniciar(cmd_iniciar), .cmd_parar(cmd_parar), .cmd_reconhecer(cmd_reconhecer),
    .sensor_nivel(sensor_nivel), .alarme_rolha(alarme_rolha),
    .aprovado(aprovado), .reprovado(reprovado),
    .esteira(esteira), .valvula_ativa(valvula_ativa), .vedacao_ativa(vedacao_ativa),
    .decrementar_rolha(decrementar_rolha), .posicao_cq(posicao_cq),
    .descarte_ativo(descarte_ativo), .garrafa_aprovada(garrafa_aprovada),
    .duzia_completa(duzia_completa), .falha(falha), .codigo_falha(codigo_falha),
    .cnt_aprovadas(cnt_aprovadas), .cnt_descartadas(cnt_descartadas)
  );

  always #5 clk = ~clk;

  typedef enum {B_IDLE, B_EST, B_ENCH, B_VED, B_CQ, B_DESC, B_APR, B_FALHA} bst_t;

  // input bits {iniciar, parar, reconhecer, sensor, alarme, aprovado, reprovado}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] I_INI = 7'b1000000;
  localparam logic [6:0] I_PAR = 7'b0100000;
  localparam logic [6:0] I_REC = 7'b0010000;
  localparam logic [6:0] I_SEN = 7'b0001000;
  localparam logic [6:0] I_ALA = 7'b0000100;
  localparam logic [6:0] I_APR = 7'b0000010;
  localparam logic [6:0] I_REP = 7'b0000001;

  // pulse bits {decrementar_rolha, garrafa_aprovada, duzia_completa}
  localparam logic [2:0] P_DEC = 3'b100;
  localparam logic [2:0] P_GAR = 3'b010;
  localparam logic [2:0] P_DUZ = 3'b001;

  typedef struct {
    logic [6:0]  in;
    logic [18:0] exp;
  } vec_t;

  vec_t        tab[$];
  logic [18:0] sb[$];
  logic [1:0]  e_code;
  logic [3:0]  e_ca, e_cd;
  int          checks = 0;
  int          passes = 0;

  logic [18:0] act;
  assign act = {esteira, valvula_ativa, vedacao_ativa, posicao_cq, descarte_ativo, falha,
                decrementar_rolha, garrafa_aprovada, duzia_completa,
                codigo_falha, cnt_aprovadas, cnt_descartadas};

  function automatic logic [18:0] mk(bst_t st, logic [2:0] p, logic [1:0] code,
                                     logic [3:0] ca, logic [3:0] cd);
    return {st == B_EST, st == B_ENCH, st == B_VED, st == B_CQ, st == B_DESC, st == B_FALHA,
            p, code, ca, cd};
  endfunction

  task automatic add(input logic [6:0] in, input bst_t st, input logic [2:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      vec_t v;
      v.in  = in;
      v.exp = mk(st, p, e_code, e_ca, e_cd);
      tab.push_back(v);
    end
  endtask

  // From the first ESTEIRA sample up to the bottle arriving at QC.
  task automatic to_cq();
    add(NONE,  B_EST,  3'b000, T_EST - 1);
    add(NONE,  B_ENCH, 3'b000, 1);
    add(I_SEN, B_VED,  P_DEC,  1);
    add(NONE,  B_VED,  3'b000, T_VED - 1);
    add(NONE,  B_CQ,   3'b000, 1);
  endtask

  task automatic check(input string name, input logic [18:0] a, input logic [18:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s actual=%b required=%b", name, a, e);
  endtask

  task automatic drive(input logic [6:0] in);
    {cmd_iniciar, cmd_parar, cmd_reconhecer, sensor_nivel, alarme_rolha, aprovado, reprovado} = in;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    e_code = 2'b00; e_ca = 4'd0; e_cd = 4'd0;

    // Idle without start stays idle
    add(NONE, B_IDLE, 3'b000, 2);
    // Bottles 1..3 accepted; third closes the batch; stop requested during its accept phase
    add(I_INI, B_EST, 3'b000, 1);
    to_cq();
    e_ca = 4'd1;
    add(I_APR, B_APR, P_GAR, 1);
    add(NONE, B_APR, 3'b000, T_APR - 1);
    add(NONE, B_EST, 3'b000, 1);
    to_cq();
    e_ca = 4'd2;
    add(I_APR, B_APR, P_GAR, 1);
    add(NONE, B_APR, 3'b000, T_APR - 1);
    add(NONE, B_EST, 3'b000, 1);
    to_cq();
    e_ca = 4'd3;
    add(I_APR, B_APR, P_GAR | P_DUZ, 1);
    add(I_PAR, B_APR, 3'b000, 1);
    add(NONE, B_APR, 3'b000, T_APR - 2);
    add(NONE, B_IDLE, 3'b000, 1);
    // Cork alarm during fill (beats the level sensor); ack ignored while alarm high
    add(I_INI, B_EST, 3'b000, 1);
    add(NONE, B_EST, 3'b000, T_EST - 1);
    add(NONE, B_ENCH, 3'b000, 1);
    e_code = 2'b01;
    add(I_SEN | I_ALA, B_FALHA, 3'b000, 1);
    add(I_REC | I_ALA, B_FALHA, 3'b000, 2);
    add(I_ALA, B_FALHA, 3'b000, 1);
    e_code = 2'b00;
    add(I_REC, B_IDLE, 3'b000, 1);
    // Fill timeout after exactly T_ENCH cycles in ENCHENDO
    add(I_INI, B_EST, 3'b000, 1);
    add(NONE, B_EST, 3'b000, T_EST - 1);
    add(NONE, B_ENCH, 3'b000, T_ENCH);
    e_code = 2'b10;
    add(NONE, B_FALHA, 3'b000, 1);
    e_code = 2'b00;
    add(I_REC, B_IDLE, 3'b000, 1);
    // Level sensor on the very last fill cycle still wins over the timeout
    add(I_INI, B_EST, 3'b000, 1);
    add(NONE, B_EST, 3'b000, T_EST - 1);
    add(NONE, B_ENCH, 3'b000, T_ENCH);
    add(I_SEN, B_VED, P_DEC, 1);
    add(NONE, B_VED, 3'b000, T_VED - 1);
    add(NONE, B_CQ, 3'b000, 1);
    // Conflicting QC holds; reject discards; stop during discard returns to IDLE
    add(I_APR | I_REP, B_CQ, 3'b000, 2);
    add(NONE, B_CQ, 3'b000, 1);
    e_cd = 4'd1;
    add(I_REP, B_DESC, 3'b000, 1);
    add(I_PAR, B_DESC, 3'b000, 1);
    add(NONE, B_DESC, 3'b000, T_DESC - 2);
    add(NONE, B_IDLE, 3'b000, 1);
    // QC with no decision
    add(I_INI, B_EST, 3'b000, 1);
    to_cq();
`ifdef FSM_CQ_TIMEOUT_EN
    add(NONE, B_CQ, 3'b000, T_CQ - 1);
    e_cd = 4'd2;
    add(NONE, B_DESC, 3'b000, T_DESC);
    add(NONE, B_EST, 3'b000, 1);
`else
    add(NONE, B_CQ, 3'b000, 10);
    e_ca = 4'd4;
    add(I_APR, B_APR, P_GAR, 1);
    add(NONE, B_APR, 3'b000, T_APR - 1);
    add(NONE, B_EST, 3'b000, 1);
`endif
    // Run into sealing, then reset is applied by hand below
    add(NONE, B_EST, 3'b000, T_EST - 1);
    add(NONE, B_ENCH, 3'b000, 1);
    add(I_SEN, B_VED, P_DEC, 1);
    add(NONE, B_VED, 3'b000, 1);

    reset = 1'b1;
    drive(NONE);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", act, 19'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tab.size(); i++) begin
      @(negedge clk);
      drive(tab[i].in);
      sb.push_back(tab[i].exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_empty vec%0d", i);
      end else begin
        check($sformatf("vec%0d", i), act, sb.pop_front());
      end
    end

    // Reset mid-VEDANDO aborts immediately
    @(negedge clk);
    drive(NONE);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_vedando", act, 19'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(I_INI);
    @(posedge clk);
    #1;
    check("restart_after_reset", act, mk(B_EST, 3'b000, 2'b00, 4'd0, 4'd0));
    @(negedge clk);
    drive(NONE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
